// File: rtl/eq_band_mac_scheduler.sv
// Gain-weighted band summer: one shared signed MAC sequenced over NUM_BANDS bands per audio sample.
// Latency NUM_BANDS+1 cycles; strobes that arrive while busy are dropped and flagged. Optional EQ_SAT_EN clamps the output.
`timescale 1ns/1ps
module eq_band_mac_scheduler #(
    parameter int NUM_BANDS = 10,
    parameter int DW        = 24,
    parameter int GW        = 13,
    parameter int ACC_W     = 41
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic [NUM_BANDS*DW-1:0] band_in,
    input  logic [NUM_BANDS*GW-1:0] gain_in,
    input  logic                    ovr_clr,
    output logic                    busy,
    output logic                    out_valid,
    output logic [DW-1:0]           audio_out,
    output logic                    overrun
);

    localparam int PW    = DW + GW;
    localparam int SHIFT = ACC_W - DW - 1;
    localparam int IW    = $clog2(NUM_BANDS);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [IW-1:0]           idx;
    logic signed [DW-1:0]    band_snap [NUM_BANDS];
    logic [GW-1:0]           gain_snap [NUM_BANDS];

    logic signed [PW-1:0]    band_x;
    logic signed [PW-1:0]    gain_x;
    logic signed [PW-1:0]    prod;
    logic [DW-1:0]           result;

    // Operands widened to the full product width so the multiply cannot lose bits.
    assign band_x = PW'(band_snap[idx]);
    assign gain_x = PW'({1'b0, gain_snap[idx]});
    assign prod   = band_x * gain_x;

`ifdef EQ_SAT_EN
    logic signed [DW:0] top;
    assign top = acc[DW+SHIFT:SHIFT];

    always_comb begin
        result = top[DW-1:0];
        if (top[DW] != top[DW-1])
            result = top[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`else
    assign result = acc[DW+SHIFT-1:SHIFT];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            audio_out <= '0;
            overrun   <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            for (int i = 0; i < NUM_BANDS; i++) begin
                band_snap[i] <= '0;
                gain_snap[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;

            // A drop and a clear in the same cycle leave the flag set.
            if (sample_valid && state != IDLE)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        for (int i = 0; i < NUM_BANDS; i++) begin
                            band_snap[i] <= band_in[i*DW +: DW];
                            gain_snap[i] <= gain_in[i*GW +: GW];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                        busy  <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (idx == IW'(NUM_BANDS - 1)) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    audio_out <= result;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mac_scheduler.sv
// Directed and randomized bench for eq_band_mac_scheduler against an arithmetic weighted-sum model.
`timescale 1ns/1ps
module tb_eq_band_mac_scheduler;

    localparam int NB = 10;
    localparam int DW = 24;
    localparam int GW = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_valid;
    logic [NB*DW-1:0]  band_in;
    logic [NB*GW-1:0]  gain_in;
    logic              ovr_clr;
    logic              busy;
    logic              out_valid;
    logic [DW-1:0]     audio_out;
    logic              overrun;

    eq_band_mac_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .band_in      (band_in),
        .gain_in      (gain_in),
        .ovr_clr      (ovr_clr),
        .busy         (busy),
        .out_valid    (out_valid),
        .audio_out    (audio_out),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] bands [NB];
    logic [GW-1:0] gains [NB];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pack();
        for (int i = 0; i < NB; i++) begin
            band_in[i*DW +: DW] = bands[i];
            gain_in[i*GW +: GW] = gains[i];
        end
    endtask

    task automatic fill(input logic [DW-1:0] b, input logic [GW-1:0] g);
        for (int i = 0; i < NB; i++) begin
            bands[i] = b;
            gains[i] = g;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NB; i++) begin
            bands[i] = DW'($urandom());
            gains[i] = GW'($urandom());
        end
    endtask

    // Sum of signed sample times unsigned gain, floored by 2^16, then clamped or wrapped.
    function automatic logic [DW-1:0] model();
        longint s = 0;
        longint t;
        for (int i = 0; i < NB; i++)
            s += longint'($signed(bands[i])) * longint'({1'b0, gains[i]});
        t = s >>> 16;
`ifdef EQ_SAT_EN
        if (t > 64'sd8388607)       t = 64'sd8388607;
        else if (t < -64'sd8388608) t = -64'sd8388608;
`endif
        return t[DW-1:0];
    endfunction

    // Present the current band/gain set for one acceptance edge; returns at the negedge after it.
    task automatic accept();
        pack();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [DW-1:0] exp, input int exp_lat);
        int lat  = 0;
        int bcnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_val"}, {8'h0, audio_out}, {8'h0, exp});
        check({tag, "_busycyc"}, bcnt, exp_lat);
        check({tag, "_busy_at_out"}, {31'h0, busy}, 32'h0);
    endtask

    logic [DW-1:0] exp_v;
    int            ov_cnt;

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        ovr_clr      = 1'b0;
        fill('0, '0);
        pack();
        @(negedge clk);
        repeat (3) step();
        check("rst_busy",      {31'h0, busy},      32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_audio",     {8'h0, audio_out},  32'h0);
        check("rst_overrun",   {31'h0, overrun},   32'h0);
        rst = 1'b0;
        step();

        fill(24'h000100, 13'h1000);
        accept();
        wait_out("unity", 24'h0000A0, 11);
        check("unity_ovr", {31'h0, overrun}, 32'h0);
        step();
        check("unity_pulse", {31'h0, out_valid}, 32'h0);

        fill('0, '0);
        bands[3] = 24'hFFFC18;
        gains[3] = 13'h0800;
        accept();
        wait_out("neg_floor", 24'hFFFFE0, 11);

        fill(24'h7FFFFF, 13'h1FFF);
        accept();
`ifdef EQ_SAT_EN
        wait_out("pos_ovf", 24'h7FFFFF, 11);
`else
        wait_out("pos_ovf", 24'h9FFAFE, 11);
`endif

        fill(24'h800000, 13'h1FFF);
        accept();
`ifdef EQ_SAT_EN
        wait_out("neg_ovf", 24'h800000, 11);
`else
        wait_out("neg_ovf", 24'h600500, 11);
`endif

        for (int n = 0; n < 8; n++) begin
            fill_random();
            accept();
            wait_out("rand", model(), 11);
        end

        // Snapshot: second strobe with altered gains lands mid-sample and is dropped.
        fill_random();
        exp_v = model();
        accept();
        repeat (4) step();
        for (int i = 0; i < NB; i++) gains[i] = gains[i] ^ 13'h1555;
        pack();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        wait_out("snapshot", exp_v, 6);
        check("snap_ovr", {31'h0, overrun}, 32'h1);
        step();
        check("snap_dropped", {31'h0, busy}, 32'h0);

        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("ovr_clr", {31'h0, overrun}, 32'h0);

        fill_random();
        exp_v = model();
        accept();
        step();
        sample_valid = 1'b1;
        ovr_clr      = 1'b1;
        step();
        sample_valid = 1'b0;
        ovr_clr      = 1'b0;
        check("set_beats_clr", {31'h0, overrun}, 32'h1);
        wait_out("set_clr_run", exp_v, 9);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("clr_alone", {31'h0, overrun}, 32'h0);

        // Strobe landing on the DONE edge is still an overrun.
        fill_random();
        exp_v = model();
        accept();
        repeat (10) step();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        wait_out("done_edge", exp_v, 0);
        check("done_edge_ovr", {31'h0, overrun}, 32'h1);
        step();
        check("done_edge_dropped", {31'h0, busy}, 32'h0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;

        fill_random();
        accept();
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy",  {31'h0, busy},      32'h0);
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_audio", {8'h0, audio_out},  32'h0);
        step();
        fill_random();
        accept();
        wait_out("post_rst", model(), 11);

        // Held strobe: accepted each time the engine returns to idle.
        fill_random();
        exp_v = model();
        pack();
        ov_cnt = 0;
        sample_valid = 1'b1;
        repeat (25) begin
            step();
            if (out_valid) ov_cnt++;
        end
        sample_valid = 1'b0;
        check("held_outs", ov_cnt, 32'd2);
        check("held_ovr",  {31'h0, overrun}, 32'h1);
        check("held_val",  {8'h0, audio_out}, {8'h0, exp_v});
        wait_out("held_last", exp_v, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
